// File: rtl/z80_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : z80_bus_arbiter
//  Description : Arbitrates Z80 memory-bus ownership between the CPU and a
//                DMA engine, bounds DMA bursts, inserts SDRAM wait states and
//                produces the CPU clock-gate enables (pause, DMA, wait).
//  Revision    : 1.0 - initial release
// ============================================================================
module z80_bus_arbiter #(
    parameter int DMA_MAX_BURST = 64,
    parameter int CPU_SLOT      = 8,
    parameter int WAIT_STATES   = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cpu_mreq_n,
    input  logic sdram_ready,
    input  logic pause,
    input  logic dma_req,
    output logic dma_grant,
    output logic clk_ctrl,
    output logic clk_ctrl_DMA,
    output logic ram_wait
);

    localparam int c_BURST_W = (DMA_MAX_BURST > 1) ? $clog2(DMA_MAX_BURST) : 1;
    localparam int c_SLOT_W  = $clog2(CPU_SLOT + 1);
    localparam int c_WAIT_W  = $clog2(WAIT_STATES + 1);

    localparam logic [c_BURST_W-1:0] c_BURST_LAST = c_BURST_W'(DMA_MAX_BURST - 1);
    localparam logic [c_SLOT_W-1:0]  c_SLOT_LOAD  = c_SLOT_W'(CPU_SLOT);
    localparam logic [c_WAIT_W-1:0]  c_WAIT_LOAD  = c_WAIT_W'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_CPU_OWN   = 2'd0,
        S_DRAIN     = 2'd1,
        S_DMA_OWN   = 2'd2,
        S_TURN_BACK = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_load_slot;
    logic [c_BURST_W-1:0]  r_burst;
    logic [c_SLOT_W-1:0]   r_slot;
    logic [c_WAIT_W-1:0]   r_wait_cnt;
    logic                  r_mreq_d;
    logic                  r_ram_wait;
    logic                  r_dma_grant;
    logic                  r_clk_ctrl;
    logic                  r_clk_ctrl_dma;
    logic                  w_cpu_side;
    logic                  w_mreq_fall;

    assign w_cpu_side  = (r_state == S_CPU_OWN) || (r_state == S_DRAIN);
    assign w_mreq_fall = r_mreq_d & ~cpu_mreq_n;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_CPU_OWN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a forced yield wins over a simultaneous voluntary release
    always_comb begin
        w_state_nxt = r_state;
        w_load_slot = 1'b0;
        case (r_state)
            S_CPU_OWN: begin
                // The slot counter is judged on its value after this cycle's
                // decrement, so the CPU gets exactly CPU_SLOT cycles here.
                if (dma_req && (r_slot <= c_SLOT_W'(1))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!dma_req) begin
                    w_state_nxt = S_CPU_OWN;
                end else if (cpu_mreq_n && !r_ram_wait) begin
                    w_state_nxt = S_DMA_OWN;
                end
            end
            S_DMA_OWN: begin
                if (r_burst == c_BURST_LAST) begin
                    w_state_nxt = S_TURN_BACK;
                    w_load_slot = 1'b1;
                end else if (!dma_req) begin
                    w_state_nxt = S_TURN_BACK;
                end
            end
            S_TURN_BACK: begin
                w_state_nxt = S_CPU_OWN;
            end
            default: begin
                w_state_nxt = S_CPU_OWN;
            end
        endcase
    end

    // Burst length counter: cleared while draining, counts DMA_OWN cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_burst <= '0;
        end else if (r_state == S_DRAIN) begin
            r_burst <= '0;
        end else if (r_state == S_DMA_OWN) begin
            r_burst <= r_burst + c_BURST_W'(1);
        end
    end

    // CPU slot counter: armed on a forced yield, runs down in CPU_OWN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot <= '0;
        end else if (w_load_slot) begin
            r_slot <= c_SLOT_LOAD;
        end else if ((r_state == S_CPU_OWN) && (r_slot != '0)) begin
            r_slot <= r_slot - c_SLOT_W'(1);
        end
    end

    // SDRAM wait-state generator, only meaningful while the CPU drives the bus
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mreq_d   <= 1'b1;
            r_ram_wait <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_mreq_d <= cpu_mreq_n;
            if (!w_cpu_side) begin
                r_ram_wait <= 1'b0;
                r_wait_cnt <= '0;
            end else if (w_mreq_fall) begin
                r_ram_wait <= 1'b1;
                r_wait_cnt <= c_WAIT_LOAD;
            end else if (r_ram_wait) begin
                if (r_wait_cnt != '0) begin
                    r_wait_cnt <= r_wait_cnt - c_WAIT_W'(1);
                end else if (sdram_ready) begin
                    r_ram_wait <= 1'b0;
                end
            end
        end
    end

    // Registered bus/clock-gate outputs, aligned with the state they describe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dma_grant    <= 1'b0;
            r_clk_ctrl     <= 1'b0;
            r_clk_ctrl_dma <= 1'b1;
        end else begin
            r_dma_grant    <= (w_state_nxt == S_DMA_OWN);
            r_clk_ctrl     <= ~pause;
            r_clk_ctrl_dma <= ~((w_state_nxt == S_DMA_OWN) || (w_state_nxt == S_TURN_BACK));
        end
    end

    assign dma_grant    = r_dma_grant;
    assign clk_ctrl     = r_clk_ctrl;
    assign clk_ctrl_DMA = r_clk_ctrl_dma;
    assign ram_wait     = r_ram_wait;

endmodule
`default_nettype wire

// File: tb/tb_z80_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_z80_bus_arbiter
//  Description : Self-checking bench for z80_bus_arbiter: vector table with
//                expected outputs plus multi-cycle burst/reset/pause sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_z80_bus_arbiter;

    logic clk;
    logic reset_n;
    logic cpu_mreq_n;
    logic sdram_ready;
    logic pause;
    logic dma_req;
    logic dma_grant;
    logic clk_ctrl;
    logic clk_ctrl_DMA;
    logic ram_wait;

    // inputs: rst_n mreq_n rdy pause req | expected: grant clk_ctrl clk_ctrl_DMA ram_wait
    typedef struct packed {
        logic rst_n;
        logic mreq_n;
        logic rdy;
        logic pse;
        logic req;
        logic g;
        logic cc;
        logic ccd;
        logic rw;
    } vec_t;

    vec_t tbl[$];
    vec_t ptbl[$];
    vec_t exp_q[$];
    int   len_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    z80_bus_arbiter #(
        .DMA_MAX_BURST (64),
        .CPU_SLOT      (8),
        .WAIT_STATES   (2)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_mreq_n   (cpu_mreq_n),
        .sdram_ready  (sdram_ready),
        .pause        (pause),
        .dma_req      (dma_req),
        .dma_grant    (dma_grant),
        .clk_ctrl     (clk_ctrl),
        .clk_ctrl_DMA (clk_ctrl_DMA),
        .ram_wait     (ram_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        vec_t e;
        reset_n     = v.rst_n;
        cpu_mreq_n  = v.mreq_n;
        sdram_ready = v.rdy;
        pause       = v.pse;
        dma_req     = v.req;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".dma_grant"},    int'(dma_grant),    int'(e.g));
        chk({tag, ".clk_ctrl"},     int'(clk_ctrl),     int'(e.cc));
        chk({tag, ".clk_ctrl_DMA"}, int'(clk_ctrl_DMA), int'(e.ccd));
        chk({tag, ".ram_wait"},     int'(ram_wait),     int'(e.rw));
        chk({tag, ".grant_vs_wait"}, int'(dma_grant & ram_wait), 0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            run_vec($sformatf("rst%0d", i), tbl[i]);
        end
    endtask

    // Counts consecutive samples on which dma_grant equals 'want', bounded
    task automatic measure(input logic want, input int bound, output int n);
        n = 0;
        while ((dma_grant === want) && (n < bound)) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        int e;

        reset_n     = 1'b0;
        cpu_mreq_n  = 1'b1;
        sdram_ready = 1'b1;
        pause       = 1'b0;
        dma_req     = 1'b0;

        // Reset, then release
        tbl.push_back(9'b01100_0010);
        tbl.push_back(9'b01100_0010);
        tbl.push_back(9'b11100_0110);
        // Access with SDRAM ready: ram_wait high exactly 2 cycles
        tbl.push_back(9'b10100_0111);
        tbl.push_back(9'b10100_0111);
        tbl.push_back(9'b10100_0110);
        tbl.push_back(9'b11100_0110);
        // Access with SDRAM not ready for 5 extra cycles: 7 cycles of wait
        for (int i = 0; i < 7; i++) tbl.push_back(9'b10000_0111);
        tbl.push_back(9'b10100_0110);
        tbl.push_back(9'b11100_0110);
        // Grant with CPU idle, 10 grant cycles, voluntary release
        tbl.push_back(9'b11101_0110);
        for (int i = 0; i < 10; i++) tbl.push_back(9'b11101_1100);
        tbl.push_back(9'b11100_0100);
        tbl.push_back(9'b11100_0110);
        // Request arriving mid-access must wait for wait-clear and MREQ high
        tbl.push_back(9'b10000_0111);
        tbl.push_back(9'b10001_0111);
        tbl.push_back(9'b10001_0111);
        tbl.push_back(9'b10101_0110);
        tbl.push_back(9'b10101_0110);
        tbl.push_back(9'b11101_1100);
        tbl.push_back(9'b11101_1100);
        tbl.push_back(9'b11100_0100);
        tbl.push_back(9'b11100_0110);
        // Request withdrawn during DRAIN: no grant
        tbl.push_back(9'b11101_0110);
        tbl.push_back(9'b11100_0110);
        tbl.push_back(9'b11100_0110);
        // Pause gates clk_ctrl one cycle later
        tbl.push_back(9'b11110_0010);
        tbl.push_back(9'b11100_0110);

        // Pause during a CPU access with DMA pending
        ptbl.push_back(9'b10111_0011);
        ptbl.push_back(9'b10111_0011);
        for (int i = 0; i < 4; i++) ptbl.push_back(9'b10111_0010);
        ptbl.push_back(9'b10101_0110);
        ptbl.push_back(9'b10101_0110);
        ptbl.push_back(9'b11101_1100);
        ptbl.push_back(9'b11100_0100);
        ptbl.push_back(9'b11100_0110);

        foreach (tbl[i]) begin
            run_vec($sformatf("v%0d", i), tbl[i]);
        end

        // Continuous request: latency 2, windows of 64, gaps of 10
        do_reset();
        len_q.push_back(2);
        len_q.push_back(64);
        len_q.push_back(10);
        len_q.push_back(64);
        cpu_mreq_n = 1'b1;
        dma_req    = 1'b1;
        measure(1'b0, 20, n);
        e = len_q.pop_front();
        chk("burst.latency", n, e);
        measure(1'b1, 200, n);
        e = len_q.pop_front();
        chk("burst.window1", n, e);
        measure(1'b0, 50, n);
        e = len_q.pop_front();
        chk("burst.gap", n, e);
        measure(1'b1, 200, n);
        e = len_q.pop_front();
        chk("burst.window2", n, e);
        dma_req = 1'b0;

        // Pause interaction
        do_reset();
        foreach (ptbl[i]) begin
            run_vec($sformatf("p%0d", i), ptbl[i]);
        end

        // Reset asserted mid-DMA drops the grant without a clock edge
        do_reset();
        run_vec("rd0", 9'b11101_0110);
        run_vec("rd1", 9'b11101_1100);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rstdma.dma_grant",    int'(dma_grant),    0);
        chk("rstdma.clk_ctrl_DMA", int'(clk_ctrl_DMA), 1);
        chk("rstdma.clk_ctrl",     int'(clk_ctrl),     0);
        @(posedge clk);
        #1;
        run_vec("rd2", 9'b01101_0010);
        run_vec("rd3", 9'b11100_0110);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
